if_stage: RTL
=============

Name: if_stage

Overview:
- Fetch stage that holds the architectural PC and drives the instruction-memory request/acknowledge handshake.
- Sits directly upstream of the next-PC logic. It presents pc_out as the old PC and loads npc_in when decode consumes the current instruction.
- Buffers one fetched instruction with a valid/ready handshake toward decode.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, width of PC and instruction-memory address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- npc_in  in  ADDR_W  next PC from the next-PC logic.
- pc_out  out  ADDR_W  current PC; feeds the next-PC logic as the old PC.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc_out whenever imem_req=1.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction for decode.
- inst_out  out  32  buffered instruction.
- inst_pc  out  ADDR_W  PC of the buffered instruction.
- id_ready  in  1  decode accepts the instruction this cycle.
- fetch_err  out  1  misaligned next PC detected (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset: while rst=1 at an edge, the next state is
  - pc_out=RESET_PC, state=IDLE, imem_req=0, inst_valid=0
  - inst_out=0, inst_pc=0, fetch_err=0
- rst has priority over every other event. An imem_ack or id_ready arriving in a cycle with rst=1 is ignored, so reset mid-fetch discards any in-flight response.
- The FSM has four states: IDLE, REQ, HOLD, ERR (ERR exists only with the feature).
- IDLE:
  - Lasts exactly one cycle after reset deasserts; then the FSM goes to REQ.
  - imem_req=0.
- REQ:
  - imem_req=1 and imem_addr=pc_out, both held stable until imem_ack.
  - On an edge with imem_ack=1: inst_out<=imem_rdata, inst_pc<=pc_out, inst_valid<=1, go to HOLD.
  - imem_req and imem_addr are registered outputs, so imem_req is 0 in HOLD.
- HOLD:
  - inst_valid=1 and pc_out equals inst_pc, so the next-PC logic computes from this instruction's PC.
  - On an edge with id_ready=1: pc_out<={npc_in[ADDR_W-1:2],2'b00}, inst_valid<=0, go to REQ.
  - With id_ready=0, all outputs are held indefinitely (stall).
- imem_ack while imem_req=0 (IDLE, HOLD, ERR) is ignored.
- Throughput and latency:
  - Minimum 2 cycles per instruction (ack in the first REQ cycle, id_ready high on the first HOLD cycle).
  - Wait states extend REQ one cycle each.
- PC arithmetic is modulo 2^ADDR_W; npc_in wrapping past 32'hFFFF_FFFC is loaded unchanged.
- pc_out changes only on a reset edge or a HOLD&id_ready edge.

Optional Feature:
- Macro: IF_STAGE_ALIGN_CHECK_EN.
- Defined:
  - On a HOLD&id_ready edge, if npc_in[1:0]!=0, the FSM goes to ERR instead of REQ.
  - pc_out<=npc_in (unmasked, for debug), fetch_err<=1, inst_valid<=0.
  - ERR is sticky until rst; imem_req stays 0.
- Not defined:
  - The ERR state and check logic are absent; npc_in[1:0] is silently forced to 0.
  - fetch_err is tied 0.

Test Plan:
- Reset release: rst 1 for 2 cycles then 0 -> pc_out=32'h3000 and imem_req=0 for one cycle, then imem_req=1 with imem_addr=32'h3000.
- Zero-wait fetch: ack same cycle with rdata=32'h2008_0005, id_ready=1, npc_in=32'h3004 -> inst_valid=1 and inst_out=32'h2008_0005 with inst_pc=32'h3000 next cycle; one cycle later pc_out=32'h3004 and imem_req=1.
- Memory wait states: ack delayed 3 cycles -> imem_req/imem_addr=32'h3004 stable for 4 cycles; inst_valid asserts the cycle after ack.
- Decode stall: id_ready=0 for 5 cycles in HOLD, then npc_in changes 32'h3008 -> 32'h3100 -> outputs frozen during the stall; pc_out=32'h3100 after id_ready=1.
- Reset mid-fetch: rst=1 in a REQ cycle with imem_ack=1 -> inst_valid stays 0, pc_out=32'h3000, FSM in IDLE.
- Misaligned npc_in=32'h3006: with IF_STAGE_ALIGN_CHECK_EN -> fetch_err=1, pc_out=32'h3006, imem_req stays 0 until rst; without the macro -> pc_out=32'h3004, fetch continues.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC register, imem handshake, one-entry instruction buffer to decode
// Optional misaligned-next-PC trap enabled by defining IF_STAGE_ALIGN_CHECK_EN.
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] npc_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              id_ready,
    output logic              fetch_err
);

`ifdef IF_STAGE_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              req_q;
    logic              valid_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              capture;
    logic              accept;
    logic              set_err;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        set_err    = 1'b0;
        pc_d       = npc_in & {{(ADDR_W-2){1'b1}}, 2'b00};
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    accept     = 1'b1;
                    state_next = REQ;
`ifdef IF_STAGE_ALIGN_CHECK_EN
                    // Trapped PC is kept unmasked so the faulting target is visible
                    if (npc_in[1:0] != 2'b00) begin
                        set_err    = 1'b1;
                        pc_d       = npc_in;
                        state_next = ERR;
                    end
`endif
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= '0;
        end else begin
            state <= state_next;
            req_q <= (state_next == REQ);
            if (capture) begin
                inst_q    <= imem_rdata;
                inst_pc_q <= pc_q;
                valid_q   <= 1'b1;
            end
            if (accept) begin
                pc_q    <= pc_d;
                valid_q <= 1'b0;
            end
        end
    end

`ifdef IF_STAGE_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign pc_out     = pc_q;
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst_out   = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
